// File: rtl/smbus_slave.sv
// smbus_slave: SMBus/I2C target with an internal byte register bank.
// SCL/SDA are oversampled on bus_clk. The host side reads the bank through a
// registered port and writes it directly. Each committed SMBus data byte is
// reported as a one-cycle strobe carrying its index and value.
// Optional glitch filter on SCL/SDA: define SMB_SLAVE_FILTER_EN.
module smbus_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NREGS_LOG2 = 4,
    parameter int         FILTER_LEN = 4
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst_n,
    input  logic                  smb_sclk,
    inout  wire                   smb_sdata,
    input  logic [NREGS_LOG2-1:0] host_addr,
    input  logic [7:0]            host_wdata,
    input  logic                  host_wren,
    output logic [7:0]            host_rdata,
    output logic                  smb_wr_strobe,
    output logic [NREGS_LOG2-1:0] smb_wr_addr,
    output logic [7:0]            smb_wr_data,
    output logic                  busy
);

    localparam int NREGS = 1 << NREGS_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    // Input conditioning
    logic scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
    logic scl_f_s, sda_f_s;
    logic scl_prev_r, sda_prev_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s;

    // Protocol engine
    state_t                state_r;
    logic [2:0]            bit_cnt_r;
    logic [7:0]            shift_r;
    logic                  first_r;
    logic                  rw_r;
    logic                  ack_phase_r;
    logic                  sda_oe_r;
    logic                  busy_r;
    logic [NREGS_LOG2-1:0] ptr_r;
    logic                  strobe_r;
    logic [NREGS_LOG2-1:0] wr_addr_r;
    logic [7:0]            wr_data_r;
    logic [7:0]            host_rdata_r;
    logic [7:0]            bank_r [NREGS];
    logic [7:0]            in_byte_s;
    logic [7:0]            bank_ptr_s;

    // Open-drain emulation: only ever pull low or release.
    assign smb_sdata = sda_oe_r ? 1'b0 : 1'bz;

    // Two-flop synchronizers; the bus idles high, so reset to 1.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            scl_meta_r <= smb_sclk;
            scl_sync_r <= scl_meta_r;
            sda_meta_r <= smb_sdata;
            sda_sync_r <= sda_meta_r;
        end
    end

`ifdef SMB_SLAVE_FILTER_EN
    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [FCNT_W-1:0] scl_cnt_r, sda_cnt_r;
    logic              scl_filt_r, sda_filt_r;

    // Stability filter: a line's output follows its input only after FILTER_LEN equal samples.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            scl_cnt_r  <= {FCNT_W{1'b0}};
            sda_cnt_r  <= {FCNT_W{1'b0}};
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
        end else begin
            if (scl_sync_r == scl_filt_r) begin
                scl_cnt_r <= {FCNT_W{1'b0}};
            end else if (scl_cnt_r == FCNT_W'(FILTER_LEN - 1)) begin
                scl_filt_r <= scl_sync_r;
                scl_cnt_r  <= {FCNT_W{1'b0}};
            end else begin
                scl_cnt_r <= scl_cnt_r + FCNT_W'(1);
            end
            if (sda_sync_r == sda_filt_r) begin
                sda_cnt_r <= {FCNT_W{1'b0}};
            end else if (sda_cnt_r == FCNT_W'(FILTER_LEN - 1)) begin
                sda_filt_r <= sda_sync_r;
                sda_cnt_r  <= {FCNT_W{1'b0}};
            end else begin
                sda_cnt_r <= sda_cnt_r + FCNT_W'(1);
            end
        end
    end

    assign scl_f_s = scl_filt_r;
    assign sda_f_s = sda_filt_r;
`else
    // Unfiltered: synchronizer outputs feed the edge detector directly.
    // FILTER_LEN only matters to the filtered build, so both arms are plain wires.
    if (FILTER_LEN > 0) begin : g_nofilt
        assign scl_f_s = scl_sync_r;
        assign sda_f_s = sda_sync_r;
    end else begin : g_nofilt_zero
        assign scl_f_s = scl_sync_r;
        assign sda_f_s = sda_sync_r;
    end
`endif

    // Previous conditioned levels for edge and START/STOP detection.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_f_s;
            sda_prev_r <= sda_f_s;
        end
    end

    assign scl_rise_s = scl_f_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_f_s & scl_prev_r;
    assign start_s    = scl_f_s & scl_prev_r & sda_prev_r & ~sda_f_s;
    assign stop_s     = scl_f_s & scl_prev_r & ~sda_prev_r & sda_f_s;

    assign in_byte_s  = {shift_r[6:0], sda_f_s};
    assign bank_ptr_s = bank_r[ptr_r];

    // Protocol FSM: START/STOP override any bit-level activity in the same cycle.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            first_r     <= 1'b0;
            rw_r        <= 1'b0;
            ack_phase_r <= 1'b0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            ptr_r       <= {NREGS_LOG2{1'b0}};
            strobe_r    <= 1'b0;
            wr_addr_r   <= {NREGS_LOG2{1'b0}};
            wr_data_r   <= 8'h00;
        end else begin
            strobe_r <= 1'b0;
            if (start_s) begin
                state_r     <= ST_ADDR;
                bit_cnt_r   <= 3'd0;
                ack_phase_r <= 1'b0;
                sda_oe_r    <= 1'b0;
            end else if (stop_s) begin
                state_r     <= ST_IDLE;
                ack_phase_r <= 1'b0;
                sda_oe_r    <= 1'b0;
                busy_r      <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_oe_r <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= in_byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                if (shift_r[6:0] == SLAVE_ADDR) begin
                                    state_r     <= ST_ADDR_ACK;
                                    rw_r        <= sda_f_s;
                                    busy_r      <= 1'b1;
                                    ack_phase_r <= 1'b0;
                                end else begin
                                    state_r <= ST_IGNORE;
                                    busy_r  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // First fall: pull SDA low for the ACK. Second fall: ACK clock done.
                        if (scl_fall_s) begin
                            if (!ack_phase_r) begin
                                sda_oe_r    <= 1'b1;
                                ack_phase_r <= 1'b1;
                            end else begin
                                ack_phase_r <= 1'b0;
                                bit_cnt_r   <= 3'd0;
                                if (rw_r) begin
                                    shift_r  <= bank_ptr_s;
                                    sda_oe_r <= ~bank_ptr_s[7];
                                    state_r  <= ST_RD_BYTE;
                                end else begin
                                    sda_oe_r <= 1'b0;
                                    first_r  <= 1'b1;
                                    state_r  <= ST_WR_BYTE;
                                end
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise_s) begin
                            shift_r   <= in_byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                state_r     <= ST_WR_ACK;
                                ack_phase_r <= 1'b0;
                                if (first_r) begin
                                    // Pointer byte: only the low index bits are meaningful.
                                    ptr_r   <= in_byte_s[NREGS_LOG2-1:0];
                                    first_r <= 1'b0;
                                end else begin
                                    strobe_r  <= 1'b1;
                                    wr_addr_r <= ptr_r;
                                    wr_data_r <= in_byte_s;
                                    ptr_r     <= ptr_r + NREGS_LOG2'(1);
                                end
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_phase_r) begin
                                sda_oe_r    <= 1'b1;
                                ack_phase_r <= 1'b1;
                            end else begin
                                sda_oe_r    <= 1'b0;
                                ack_phase_r <= 1'b0;
                                bit_cnt_r   <= 3'd0;
                                state_r     <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        // The MSB is already on the line; each fall presents the next bit.
                        if (scl_fall_s) begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                sda_oe_r    <= 1'b0;
                                ptr_r       <= ptr_r + NREGS_LOG2'(1);
                                ack_phase_r <= 1'b0;
                                state_r     <= ST_RD_ACK;
                            end else begin
                                shift_r  <= {shift_r[6:0], 1'b0};
                                sda_oe_r <= ~shift_r[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // Master ACK is latched on the rise; the next byte starts on the fall.
                        if (scl_rise_s) begin
                            if (sda_f_s) begin
                                state_r <= ST_IGNORE;
                                busy_r  <= 1'b0;
                            end else begin
                                ack_phase_r <= 1'b1;
                            end
                        end else if (scl_fall_s && ack_phase_r) begin
                            ack_phase_r <= 1'b0;
                            bit_cnt_r   <= 3'd0;
                            shift_r     <= bank_ptr_s;
                            sda_oe_r    <= ~bank_ptr_s[7];
                            state_r     <= ST_RD_BYTE;
                        end else begin
                            ack_phase_r <= ack_phase_r;
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe_r <= 1'b0;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register bank: an SMBus commit beats a host write to the same index.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (strobe_r && (wr_addr_r == NREGS_LOG2'(i))) begin
                    bank_r[i] <= wr_data_r;
                end else if (host_wren && (host_addr == NREGS_LOG2'(i))) begin
                    bank_r[i] <= host_wdata;
                end else begin
                    bank_r[i] <= bank_r[i];
                end
            end
        end
    end

    // Host read port, one cycle latency.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            host_rdata_r <= 8'h00;
        end else begin
            host_rdata_r <= bank_r[host_addr];
        end
    end

    assign host_rdata    = host_rdata_r;
    assign smb_wr_strobe = strobe_r;
    assign smb_wr_addr   = wr_addr_r;
    assign smb_wr_data   = wr_data_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_smbus_slave.sv
// Directed bench for smbus_slave: table of pointer+data write transactions,
// plus hand-written read, host-write, mismatch, reset and glitch sequences.
module tb_smbus_slave;

    logic       bus_clk = 1'b0;
    logic       bus_rst_n;
    logic       smb_sclk;
    logic       m_sda_low;
    wire        smb_sdata;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_wren;
    wire  [7:0] host_rdata;
    wire        smb_wr_strobe;
    wire  [3:0] smb_wr_addr;
    wire  [7:0] smb_wr_data;
    wire        busy;

    always #5 bus_clk = ~bus_clk;

    assign smb_sdata = m_sda_low ? 1'b0 : 1'bz;
    pullup (smb_sdata);

    smbus_slave #(.SLAVE_ADDR(7'h50), .NREGS_LOG2(4), .FILTER_LEN(4)) dut (
        .bus_clk(bus_clk), .bus_rst_n(bus_rst_n), .smb_sclk(smb_sclk),
        .smb_sdata(smb_sdata), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_wren(host_wren), .host_rdata(host_rdata),
        .smb_wr_strobe(smb_wr_strobe), .smb_wr_addr(smb_wr_addr),
        .smb_wr_data(smb_wr_data), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // Monitors: strobe log, busy cycles, cycles the DUT pulls SDA low.
    int          strb_cnt = 0;
    int          busy_cnt = 0;
    int          low_cnt  = 0;
    logic [11:0] strb_log [64];

    always @(negedge bus_clk) begin
        if (smb_wr_strobe) begin
            if (strb_cnt < 64) strb_log[strb_cnt] = {smb_wr_addr, smb_wr_data};
            strb_cnt = strb_cnt + 1;
        end
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (!m_sda_low && smb_sdata === 1'b0) low_cnt = low_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_x(input logic b, output logic r);
        repeat (8) @(posedge bus_clk);
        m_sda_low = ~b;
        repeat (8) @(posedge bus_clk);
        smb_sclk = 1'b1;
        repeat (8) @(posedge bus_clk);
        @(negedge bus_clk);
        r = smb_sdata;
        repeat (8) @(posedge bus_clk);
        smb_sclk = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(nack, r);
    endtask

    task automatic m_start;
        repeat (8) @(posedge bus_clk);
        m_sda_low = 1'b1;
        repeat (8) @(posedge bus_clk);
        smb_sclk = 1'b0;
    endtask

    task automatic m_rstart;
        repeat (8) @(posedge bus_clk);
        m_sda_low = 1'b0;
        repeat (8) @(posedge bus_clk);
        smb_sclk = 1'b1;
        repeat (8) @(posedge bus_clk);
        m_sda_low = 1'b1;
        repeat (8) @(posedge bus_clk);
        smb_sclk = 1'b0;
    endtask

    task automatic m_stop;
        repeat (8) @(posedge bus_clk);
        m_sda_low = 1'b1;
        repeat (8) @(posedge bus_clk);
        smb_sclk = 1'b1;
        repeat (8) @(posedge bus_clk);
        m_sda_low = 1'b0;
        repeat (16) @(posedge bus_clk);
    endtask

    task automatic host_chk(input logic [3:0] a, input logic [7:0] e, input string name);
        @(negedge bus_clk);
        host_addr = a;
        @(negedge bus_clk);
        check(name, host_rdata, e);
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] ea0;
        logic [3:0] ea1;
    } wvec_t;

    wvec_t wtab [3];

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] r0, r1;
        int         base, bbase, lbase;

        wtab[0] = '{ptr: 8'h0F, d0: 8'h11, d1: 8'h22, ea0: 4'hF, ea1: 4'h0};
        wtab[1] = '{ptr: 8'hF3, d0: 8'hC3, d1: 8'h3C, ea0: 4'h3, ea1: 4'h4};
        wtab[2] = '{ptr: 8'h03, d0: 8'hA5, d1: 8'h5A, ea0: 4'h3, ea1: 4'h4};

        bus_rst_n  = 1'b0;
        smb_sclk   = 1'b1;
        m_sda_low  = 1'b0;
        host_addr  = 4'h0;
        host_wdata = 8'h00;
        host_wren  = 1'b0;
        repeat (5) @(posedge bus_clk);
        @(negedge bus_clk);
        bus_rst_n = 1'b1;
        repeat (10) @(posedge bus_clk);

        // Reset state
        @(negedge bus_clk);
        check("rst_busy", busy, 1'b0);
        check("rst_strobe", smb_wr_strobe, 1'b0);
        check("rst_sda", smb_sdata, 1'b1);
        host_chk(4'h0, 8'h00, "rst_bank0");
        host_chk(4'hF, 8'h00, "rst_bank15");

        // Pointer + two data bytes, including the 15->0 wrap and upper-bit masking.
        for (int k = 0; k < 3; k++) begin
            base = strb_cnt;
            m_start;
            wr_byte(8'hA0, a0);
            wr_byte(wtab[k].ptr, a1);
            wr_byte(wtab[k].d0, a2);
            wr_byte(wtab[k].d1, a3);
            check("wr_acks", {a0, a1, a2, a3}, 4'b0000);
            @(negedge bus_clk);
            check("wr_busy_mid", busy, 1'b1);
            m_stop;
            @(negedge bus_clk);
            check("wr_busy_end", busy, 1'b0);
            check("wr_nstrobe", strb_cnt - base, 2);
            check("wr_strobe0", strb_log[base], {wtab[k].ea0, wtab[k].d0});
            check("wr_strobe1", strb_log[base + 1], {wtab[k].ea1, wtab[k].d1});
            host_chk(wtab[k].ea0, wtab[k].d0, "wr_bank0");
            host_chk(wtab[k].ea1, wtab[k].d1, "wr_bank1");
        end

        // Read after pointer write, master ACK then NACK.
        m_start;
        wr_byte(8'hA0, a0);
        wr_byte(8'h03, a1);
        m_rstart;
        wr_byte(8'hA1, a2);
        rd_byte(1'b0, r0);
        rd_byte(1'b1, r1);
        check("rd_acks", {a0, a1, a2}, 3'b000);
        check("rd_byte0", r0, 8'hA5);
        check("rd_byte1", r1, 8'h5A);
        @(negedge bus_clk);
        check("rd_sda_released", smb_sdata, 1'b1);
        check("rd_busy_after_nack", busy, 1'b0);
        m_stop;

        // Host write, then read it back over SMBus.
        @(negedge bus_clk);
        host_addr  = 4'h7;
        host_wdata = 8'h77;
        host_wren  = 1'b1;
        @(negedge bus_clk);
        host_wren  = 1'b0;
        m_start;
        wr_byte(8'hA0, a0);
        wr_byte(8'h07, a1);
        m_rstart;
        wr_byte(8'hA1, a2);
        rd_byte(1'b1, r0);
        m_stop;
        check("hw_acks", {a0, a1, a2}, 3'b000);
        check("hw_rd", r0, 8'h77);

        // Address mismatch: nothing driven, no strobes, never busy.
        base  = strb_cnt;
        bbase = busy_cnt;
        lbase = low_cnt;
        m_start;
        wr_byte(8'hA2, a0);
        wr_byte(8'h55, a1);
        m_stop;
        check("mm_acks", {a0, a1}, 2'b11);
        check("mm_no_drive", low_cnt - lbase, 0);
        check("mm_no_strobe", strb_cnt - base, 0);
        check("mm_no_busy", busy_cnt - bbase, 0);

        // Reset while the DUT pulls SDA low (MSB of 0x77 is 0).
        m_start;
        wr_byte(8'hA0, a0);
        wr_byte(8'h07, a1);
        m_rstart;
        wr_byte(8'hA1, a2);
        repeat (6) @(posedge bus_clk);
        @(negedge bus_clk);
        check("rst_pre_drive", smb_sdata, 1'b0);
        #2;
        bus_rst_n = 1'b0;
        #1;
        check("rst_async_release", smb_sdata, 1'b1);
        smb_sclk  = 1'b1;
        m_sda_low = 1'b0;
        repeat (4) @(posedge bus_clk);
        @(negedge bus_clk);
        bus_rst_n = 1'b1;
        repeat (10) @(posedge bus_clk);
        host_chk(4'h7, 8'h00, "rst_bank7");
        host_chk(4'h3, 8'h00, "rst_bank3");
        base = strb_cnt;
        m_start;
        wr_byte(8'hA0, a0);
        wr_byte(8'h02, a1);
        wr_byte(8'h99, a2);
        m_stop;
        check("post_rst_acks", {a0, a1, a2}, 3'b000);
        check("post_rst_strobe", strb_log[base], {4'h2, 8'h99});
        host_chk(4'h2, 8'h99, "post_rst_bank2");

        // 2-cycle SCL glitch in the middle of data byte 0xF0 at index 5.
        base = strb_cnt;
        m_start;
        wr_byte(8'hA0, a0);
        wr_byte(8'h05, a1);
        for (int i = 0; i < 4; i++) bit_x(1'b1, a2);
        repeat (3) @(posedge bus_clk);
        smb_sclk = 1'b1;
        repeat (2) @(posedge bus_clk);
        smb_sclk = 1'b0;
        for (int i = 0; i < 4; i++) bit_x(1'b0, a2);
        bit_x(1'b1, a3);
        m_stop;
        check("gl_nstrobe", strb_cnt - base, 1);
`ifdef SMB_SLAVE_FILTER_EN
        check("gl_strobe", strb_log[base], {4'h5, 8'hF0});
        check("gl_ack", a3, 1'b0);
        host_chk(4'h5, 8'hF0, "gl_bank5");
`else
        check("gl_strobe", strb_log[base], {4'h5, 8'hF8});
        check("gl_ack", a3, 1'b1);
        host_chk(4'h5, 8'hF8, "gl_bank5");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smbus_slave.md
# smbus_slave

SMBus/I2C target (responder) with an internal byte register bank, oversampled on `bus_clk`. It is the opposite end of the team's host-side SMBus initiator, and lets the FPGA expose configuration and status registers to an external SMBus master. The host-side logic reads and writes the same bank through a simple synchronous port. SMBus writes are reported to that logic as single-cycle strobes.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit target address that this block ACKs.
- `NREGS_LOG2`, default 4: register bank holds 2^NREGS_LOG2 bytes.
- `FILTER_LEN`, default 4: glitch-filter length in `bus_clk` cycles; used only with `SMB_SLAVE_FILTER_EN`.
- `bus_clk` in 1: the only clock; all logic rises on it.
- `bus_rst_n` in 1: asynchronous, active-low reset.
- `smb_sclk` in 1: SMBus clock pin, externally pulled up.
- `smb_sdata` inout 1: SMBus data pin, open-drain emulated (drives 0 or z).
- `host_addr` in NREGS_LOG2: host-side register index.
- `host_wdata` in 8: host-side write data.
- `host_wren` in 1: writes `host_wdata` to bank[`host_addr`].
- `host_rdata` out 8: bank[`host_addr`], registered, 1-cycle latency.
- `smb_wr_strobe` out 1: 1-cycle pulse when an SMBus data byte is committed.
- `smb_wr_addr` out NREGS_LOG2: index of the committed byte; valid with the strobe.
- `smb_wr_data` out 8: value of the committed byte; valid with the strobe.
- `busy` out 1: high from an address-matched ACK until STOP, NACKed read, or a non-matching repeated START.

## Operation
- **Input conditioning.** SCL and SDA each pass through a 2-FF synchronizer, then the optional filter, then a 1-FF edge detector.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **START/STOP priority.** START (including repeated START) and STOP are honoured in every state and take priority over bit processing in the same cycle.
  - START leads to ADDR.
  - STOP leads to IDLE and releases SDA.
- **States.** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
  - ADDR: shift 8 bits MSB first on SCL rising edges.
    - If bits[7:1] == SLAVE_ADDR, go to ADDR_ACK.
    - Otherwise go to IGNORE. SDA is never driven in IGNORE, and IGNORE waits for START or STOP.
  - ADDR_ACK: drive SDA=0 for the 9th clock.
    - On the 9th falling edge, R/W=0 goes to WR_BYTE with `first` set.
    - R/W=1 loads the shifter with bank[ptr] and goes to RD_BYTE.
  - WR_BYTE: shift 8 bits, then WR_ACK (always ACK).
    - If `first` is set, the byte sets ptr to byte[NREGS_LOG2-1:0]; upper bits are ignored.
    - Otherwise the byte is written to bank[ptr], the strobe pulses, and ptr increments.
  - RD_BYTE: put the shifter MSB on SDA after each SCL falling edge. After 8 bits, release SDA, increment ptr, and go to RD_ACK.
  - RD_ACK: sample SDA on the 9th rising edge.
    - 0 (ACK): reload from bank[ptr] and go to RD_BYTE.
    - 1 (NACK): go to IGNORE.
- **Pointer.** ptr is modulo 2^NREGS_LOG2, wrapping 15→0 at the default. It persists across transactions and resets to 0.
- **Bus behaviour.** No clock stretching; SCL is never driven.
- **Write collision.** If an SMBus commit and `host_wren` hit the same index in the same cycle, the SMBus write wins.

## Timing
- **SDA changes.** SDA output changes exactly 1 `bus_clk` cycle after the detected SCL falling edge, never while detected SCL is high.
- **Conditioning latency.** 3 cycles from pin to detected edge, plus FILTER_LEN when the filter is enabled.
- **Minimum SCL phase.** SCL high and low phases must each be ≥ 6 + FILTER_LEN cycles. At 150 MHz this comfortably covers 100/400 kHz.
- **Strobe latency.** `smb_wr_strobe` pulses in the cycle after the 8th rising edge of a data byte, before the ACK.
- **Reset values.** SDA released (z), state IDLE, ptr 0, bank all 0x00, `host_rdata` 0, `smb_wr_strobe` 0, `busy` 0.
- **Reset mid-operation.** Asserting reset during a transfer releases SDA immediately, asynchronously.

## Configuration
- `SMB_SLAVE_FILTER_EN` defined: SCL and SDA each get a majority/stable filter. The output changes only after the input has been stable for FILTER_LEN cycles, so pulses shorter than FILTER_LEN are ignored.
- `SMB_SLAVE_FILTER_EN` undefined: no filter, and FILTER_LEN is unused. Latency is 3 cycles, and any synchronized pulse of 1 cycle or more is treated as an edge.

## Test plan
- **Write.** Send START, 0xA0, 0x03, 0xA5, 0x5A, STOP.
  - All four bytes are ACKed.
  - Strobes (3,0xA5) and (4,0x5A) are seen.
  - `host_rdata` at index 3 and 4 reads 0xA5 and 0x5A.
  - `busy` falls after STOP.
- **Read after pointer write.** Send START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes with master ACK then NACK, STOP.
  - Data returned is 0xA5, 0x5A.
  - SDA is released after the NACK.
- **Address mismatch.** Send START, 0xA2, ….
  - SDA is never driven low, there are no strobes, and `busy` stays 0.
- **Pointer wrap.** Write pointer 0x0F, then data 0x11, 0x22.
  - bank[15]=0x11 and bank[0]=0x22.
  - A pointer byte of 0xF3 sets ptr to 3.
- **Reset mid-read.** Assert `bus_rst_n` low while the block drives SDA=0.
  - SDA is z in the same cycle.
  - After release, the bank is all 0 and the next START is handled normally.
- **Glitch filter.** With `SMB_SLAVE_FILTER_EN` and FILTER_LEN=4, inject a 2-cycle SCL pulse mid-byte: no bit shift occurs. Without the macro, the same pulse shifts a bit.
